regression_arbiter: RTL and testbench

REGRESSION_ARBITER -- requirements
Module: regression_arbiter

---
 rtl/regression_arbiter.sv | 145 ++++++++++++++
 tb/tb_regression_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regression_arbiter.sv
// Round-robin arbiter that shares one 3x3 fixed-point solver among NUM_REQ requesters.
// Each job is started, timed out and aborted if needed, and answered with one response pulse.
module regression_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req,
  input  logic signed [NUM_REQ*9*WIDTH-1:0] req_a,
  input  logic signed [NUM_REQ*3*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]                gnt,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic signed [3*WIDTH-1:0]         rsp_beta,
  output logic                              rsp_error,
  output logic                              slv_start,
  output logic                              slv_abort,
  output logic signed [9*WIDTH-1:0]         slv_a,
  output logic signed [3*WIDTH-1:0]         slv_b,
  input  logic                              slv_done,
  input  logic signed [3*WIDTH-1:0]         slv_beta,
  output logic                              busy,
  output logic [15:0]                       jobs_ok,
  output logic [15:0]                       jobs_err,
  output logic [2:0]                        state
);

  // Handshake: a requester raises req (a level) with stable operands and keeps it up
  // until its own rsp_valid pulse; rsp_valid is a one-cycle pulse on the owner's bit only.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    ABORT = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C  = CW'(TIMEOUT);
  localparam logic [IW-1:0] LAST_RESET = IW'(NUM_REQ - 1);

  state_t        state_q;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  logic          win_found;
  logic [CW-1:0] tmo_cnt;
  logic [CW-1:0] tmo_next;
  logic          abort_phase;

  assign state    = state_q;
  assign tmo_next = tmo_cnt + CW'(1);

  // Search starts one past the previous winner so every requester is served in turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_grant;
    cand      = last_grant;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(last_grant) + i) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt         <= '0;
      rsp_valid   <= '0;
      rsp_beta    <= '0;
      rsp_error   <= 1'b0;
      slv_start   <= 1'b0;
      slv_abort   <= 1'b1;
      slv_a       <= '0;
      slv_b       <= '0;
      busy        <= 1'b0;
      jobs_ok     <= '0;
      jobs_err    <= '0;
      last_grant  <= LAST_RESET;
      tmo_cnt     <= '0;
      abort_phase <= 1'b0;
    end else begin
      slv_start <= 1'b0;
      rsp_valid <= '0;
      case (state_q)
        IDLE: begin
          slv_abort <= 1'b0;
          if (win_found) begin
            gnt        <= NUM_REQ'(1) << win_idx;
            slv_a      <= req_a[int'(win_idx)*9*WIDTH +: 9*WIDTH];
            slv_b      <= req_b[int'(win_idx)*3*WIDTH +: 3*WIDTH];
            last_grant <= win_idx;
            tmo_cnt    <= '0;
            slv_start  <= 1'b1;
            busy       <= 1'b1;
            state_q    <= START;
          end
        end
        START: state_q <= WAIT;
        WAIT: begin
          tmo_cnt <= tmo_next;
          // A completion on the final allowed cycle still wins over the timeout.
          if (slv_done) begin
            rsp_beta  <= slv_beta;
            rsp_error <= 1'b0;
            rsp_valid <= gnt;
            state_q   <= RESP;
          end else if (tmo_next == TIMEOUT_C) begin
            slv_abort   <= 1'b1;
            rsp_beta    <= '0;
            rsp_error   <= 1'b1;
            abort_phase <= 1'b0;
            state_q     <= ABORT;
          end
        end
        ABORT: begin
          abort_phase <= 1'b1;
          if (abort_phase) begin
            slv_abort <= 1'b0;
            rsp_valid <= gnt;
            state_q   <= RESP;
          end
        end
        RESP: begin
          gnt     <= '0;
          busy    <= 1'b0;
          state_q <= IDLE;
          if (rsp_error) begin
            if (jobs_err != 16'hFFFF) jobs_err <= jobs_err + 16'd1;
          end else begin
            if (jobs_ok != 16'hFFFF) jobs_ok <= jobs_ok + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regression_arbiter.sv
// Directed bench for regression_arbiter: a vector table of single jobs plus hand-written
// sequences for reset mid-job, contention, fairness, timeout and the timeout boundary.
module tb_regression_arbiter;
  localparam int W = 32;
  localparam int N = 4;

  typedef struct {
    logic [N-1:0]   req;
    int             delay;
    logic [3*W-1:0] beta;
    bit             drop_early;
    bit             early_done;
    logic [N-1:0]   exp_gnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   t_req = '0;
  logic [N*9*W-1:0] req_a;
  logic [N*3*W-1:0] req_b;
  logic slv_done = 1'b0;
  logic t_done = 1'b0;
  logic [3*W-1:0] slv_beta = '0;

  logic [N-1:0]   gnt, rsp_valid;
  logic [3*W-1:0] rsp_beta, slv_b;
  logic [9*W-1:0] slv_a;
  logic           rsp_error, slv_start, slv_abort, busy;
  logic [15:0]    jobs_ok, jobs_err;
  logic [2:0]     state;

  logic [N-1:0]   t_gnt, t_rsp_valid;
  logic [3*W-1:0] t_rsp_beta, t_slv_b;
  logic [9*W-1:0] t_slv_a;
  logic           t_rsp_error, t_slv_start, t_slv_abort, t_busy;
  logic [15:0]    t_jobs_ok, t_jobs_err;
  logic [2:0]     t_state;

  int n_checks = 0;
  int n_pass = 0;
  int exp_ok = 0;
  int start_cnt = 0;
  int gnt_bad = 0;
  vec_t vecs[8];

  regression_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(255)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_beta(rsp_beta), .rsp_error(rsp_error),
    .slv_start(slv_start), .slv_abort(slv_abort), .slv_a(slv_a), .slv_b(slv_b),
    .slv_done(slv_done), .slv_beta(slv_beta), .busy(busy),
    .jobs_ok(jobs_ok), .jobs_err(jobs_err), .state(state)
  );

  regression_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(8)) u_tmo (
    .clk(clk), .rst(rst), .req(t_req), .req_a(req_a), .req_b(req_b),
    .gnt(t_gnt), .rsp_valid(t_rsp_valid), .rsp_beta(t_rsp_beta), .rsp_error(t_rsp_error),
    .slv_start(t_slv_start), .slv_abort(t_slv_abort), .slv_a(t_slv_a), .slv_b(t_slv_b),
    .slv_done(t_done), .slv_beta(slv_beta), .busy(t_busy),
    .jobs_ok(t_jobs_ok), .jobs_err(t_jobs_err), .state(t_state)
  );

  // Clock and reset-independent monitors
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!$onehot0(gnt)) gnt_bad++;
    if (slv_start) start_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [N-1:0] r, input int d, input logic [3*W-1:0] b,
                              input bit de, input bit ed, input logic [N-1:0] eg);
    vec_t v;
    v.req = r; v.delay = d; v.beta = b; v.drop_early = de; v.early_done = ed; v.exp_gnt = eg;
    return v;
  endfunction

  // Driver: one complete job from request to the idle cycle after its response.
  task automatic run_job(input vec_t v);
    int cyc;
    int owner;
    logic start_extra, unstable, early_rsp;
    owner = 0;
    for (int i = 0; i < N; i++) if (v.exp_gnt[i]) owner = i;
    req = v.req;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (gnt == '0 && cyc < 10);
    check("grant_latency", cyc, 1);
    check("gnt", gnt, v.exp_gnt);
    check("slv_start_pulse", slv_start, 1'b1);
    check("busy", busy, 1'b1);
    check("slv_a", slv_a, req_a[owner*9*W +: 9*W]);
    check("slv_b", slv_b, req_b[owner*3*W +: 3*W]);
    if (v.drop_early) req = req & ~v.exp_gnt;
    if (v.early_done) begin
      slv_beta = ~v.beta;
      slv_done = 1'b1;
    end
    start_extra = 1'b0;
    unstable = 1'b0;
    early_rsp = 1'b0;
    for (int i = 1; i <= v.delay; i++) begin
      @(negedge clk);
      slv_done = 1'b0;
      if (slv_start) start_extra = 1'b1;
      if (gnt !== v.exp_gnt || slv_a !== req_a[owner*9*W +: 9*W]) unstable = 1'b1;
      if (rsp_valid !== '0) early_rsp = 1'b1;
      if (i == v.delay) begin
        slv_beta = v.beta;
        slv_done = 1'b1;
      end
    end
    check("slv_start_once", start_extra, 1'b0);
    check("gnt_operands_stable", unstable, 1'b0);
    check("no_early_rsp", early_rsp, 1'b0);
    @(negedge clk);
    slv_done = 1'b0;
    check("rsp_valid", rsp_valid, v.exp_gnt);
    check("rsp_error", rsp_error, 1'b0);
    check("rsp_beta", rsp_beta, v.beta);
    req = req & ~v.exp_gnt;
    @(negedge clk);
    exp_ok++;
    check("idle_after_rsp", {gnt, rsp_valid, busy}, '0);
    check("jobs_ok", jobs_ok, exp_ok);
  endtask

  initial begin
    logic [N-1:0] cr, eg;
    logic stray;
    int abort_cycles, rsp_stray;

    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < 9; j++)
        req_a[(r*9+j)*W +: W] = (r == 0) ? ((j % 4 == 0) ? 32'h0001_0000 : 32'h0) : W'(r*256 + j);
      for (int j = 0; j < 3; j++)
        req_b[(r*3+j)*W +: W] = (r == 0) ? W'((j + 5) << 16) : W'(r*4096 + j);
    end

    vecs[0] = mk(4'b0001, 20, {32'h0007_0000, 32'h0006_0000, 32'h0005_0000}, 0, 0, 4'b0001);
    vecs[1] = mk(4'b0110, 3, 96'h0000_1111_0000_2222_0000_3333, 0, 0, 4'b0010);
    vecs[2] = mk(4'b0110, 1, {32'hFFFF_0000, 32'h0000_8000, 32'h8000_0000}, 1, 0, 4'b0100);
    vecs[3] = mk(4'b1001, 5, 96'h0123_4567_89AB_CDEF_0F0F_0F0F, 0, 1, 4'b1000);
    vecs[4] = mk(4'b1001, 2, 96'h0000_0001_0000_0002_0000_0003, 0, 0, 4'b0001);
    vecs[5] = mk(4'b1010, 4, {32'hFFFE_8000, 32'hFFFF_FFFF, 32'h7FFF_FFFF}, 0, 0, 4'b0010);
    vecs[6] = mk(4'b1111, 1, 96'hAAAA_5555_5555_AAAA_1234_5678, 0, 1, 4'b0100);
    vecs[7] = mk(4'b0011, 2, 96'h0003_0000_0002_0000_0001_0000, 0, 0, 4'b0001);

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", {gnt, rsp_valid, rsp_error, slv_start, busy, state}, '0);
    check("reset_counters", {jobs_ok, jobs_err, t_jobs_ok, t_jobs_err}, '0);
    check("reset_abort", {slv_abort, t_slv_abort}, 2'b11);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_job(vecs[i]);

    // Reset in the middle of a WAIT
    req = 4'b0001;
    @(negedge clk);
    check("mid_gnt", gnt, 4'b0001);
    repeat (3) @(negedge clk);
    check("mid_state_wait", state, 3'd2);
    rst = 1'b1;
    req = '0;
    #1;
    check("rst_ctl_zero", {gnt, rsp_valid, rsp_error, slv_start, busy, state}, '0);
    check("rst_beta_zero", rsp_beta, '0);
    check("rst_operands_zero", (slv_a == '0) && (slv_b == '0), 1'b1);
    check("rst_counters_zero", {jobs_ok, jobs_err}, '0);
    check("rst_abort_high", slv_abort, 1'b1);
    @(negedge clk);
    slv_done = 1'b1;
    rst = 1'b0;
    stray = 1'b0;
    repeat (3) begin
      @(negedge clk);
      slv_done = 1'b0;
      if (rsp_valid != '0 || gnt != '0) stray = 1'b1;
    end
    check("no_rsp_after_reset", stray, 1'b0);
    check("abort_released", slv_abort, 1'b0);
    exp_ok = 0;
    run_job(mk(4'b0100, 6, 96'h0000_00AA_0000_00BB_0000_00CC, 0, 0, 4'b0100));

    // Contention from a fresh reset: order 0,1,2,3 with four start pulses
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ok = 0;
    abort_cycles = start_cnt;
    cr = 4'b1111;
    for (int i = 0; i < N; i++) begin
      eg = N'(1) << i;
      run_job(mk(cr, i + 2, {3{W'(i + 1)}}, 0, 0, eg));
      cr = cr & ~eg;
    end
    check("contention_starts", start_cnt - abort_cycles, 4);

    // Fairness: requester 0 re-raises at once, requester 1 holds
    for (int i = 0; i < 4; i++) begin
      eg = (i % 2 == 0) ? 4'b0001 : 4'b0010;
      run_job(mk(4'b0011, 3, {3{W'(32'h100 + i)}}, 0, 0, eg));
    end

    // Timeout boundary on the TIMEOUT=8 instance: done on the 8th WAIT cycle succeeds
    t_req = 4'b0010;
    @(negedge clk);
    check("t_bnd_gnt", t_gnt, 4'b0010);
    check("t_bnd_start", t_slv_start, 1'b1);
    abort_cycles = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (t_slv_abort) abort_cycles++;
      if (i == 8) begin
        slv_beta = 96'h1357_9BDF_2468_ACE0_0F1E_2D3C;
        t_done = 1'b1;
      end
    end
    @(negedge clk);
    t_done = 1'b0;
    check("t_bnd_rsp_valid", t_rsp_valid, 4'b0010);
    check("t_bnd_rsp_error", t_rsp_error, 1'b0);
    check("t_bnd_rsp_beta", t_rsp_beta, 96'h1357_9BDF_2468_ACE0_0F1E_2D3C);
    check("t_bnd_no_abort", abort_cycles + int'(t_slv_abort), 0);
    t_req = '0;
    @(negedge clk);
    check("t_bnd_counters", {t_jobs_ok, t_jobs_err}, {16'd1, 16'd0});

    // Timeout: solver never finishes
    t_req = 4'b0001;
    @(negedge clk);
    check("t_to_gnt", t_gnt, 4'b0001);
    abort_cycles = 0;
    rsp_stray = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (t_slv_abort) abort_cycles++;
      if (i == 9) check("t_to_abort_error", {t_slv_abort, t_rsp_error}, 2'b11);
      if (i == 11) begin
        check("t_to_rsp_valid", t_rsp_valid, 4'b0001);
        check("t_to_rsp_error", t_rsp_error, 1'b1);
        check("t_to_rsp_beta", t_rsp_beta, '0);
        t_req = '0;
      end else if (t_rsp_valid != '0) begin
        rsp_stray++;
      end
    end
    check("t_to_abort_cycles", abort_cycles, 2);
    check("t_to_no_stray_rsp", rsp_stray, 0);
    check("t_to_counters", {t_jobs_ok, t_jobs_err}, {16'd1, 16'd1});

    check("gnt_onehot0", gnt_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
